// File: rtl/ee457_cpu_pkg.sv
// Shared CPU definitions: default register-file geometry, the r0 constant and
// the writeback request record carried by the two writeback sources.
package ee457_cpu_pkg;
    localparam int ADDR_SIZE_DEF = 5;
    localparam int DATA_SIZE_DEF = 32;
    localparam int R0            = 0;

    typedef struct packed {
        logic                     valid;
        logic [ADDR_SIZE_DEF-1:0] wa;
        logic [DATA_SIZE_DEF-1:0] wdata;
    } wb_req_t;
endpackage

// File: rtl/ee457_regfile_wb_sched_if.sv
// Writeback request channel: a source presents valid/wa/wdata and holds them
// until the scheduler raises ready.
interface ee457_regfile_wb_sched_if #(
    parameter int ADDR_SIZE = 5,
    parameter int DATA_SIZE = 32
);
    logic                 valid;
    logic [ADDR_SIZE-1:0] wa;
    logic [DATA_SIZE-1:0] wdata;
    logic                 ready;

    modport master (output valid, wa, wdata, input ready);
    modport slave  (input valid, wa, wdata, output ready);
endinterface

// File: rtl/ee457_wb_arbiter.sv
// Two-source writeback arbiter: A has priority, B wins once it has lost
// STARVE_LIMIT consecutive cycles. The winner is registered onto the rf port.
module ee457_wb_arbiter
    import ee457_cpu_pkg::*;
#(
    parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [ADDR_SIZE-1:0] a_wa,
    input  logic [DATA_SIZE-1:0] a_wdata,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [ADDR_SIZE-1:0] b_wa,
    input  logic [DATA_SIZE-1:0] b_wdata,
    output logic                 b_ready,
    output logic                 rf_wen,
    output logic [ADDR_SIZE-1:0] rf_wa,
    output logic [DATA_SIZE-1:0] rf_wdata
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]     starve_cnt_reg, starve_cnt_next;
    logic                 force_b;
    logic                 granted;
    logic [ADDR_SIZE-1:0] grant_wa;
    logic [DATA_SIZE-1:0] grant_wdata;
    logic                 rf_wen_next;
    logic [ADDR_SIZE-1:0] rf_wa_next;
    logic [DATA_SIZE-1:0] rf_wdata_next;

    assign force_b = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
    assign a_ready = a_valid & ~force_b;
    assign b_ready = b_valid & (~a_valid | force_b);

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!b_valid || b_ready)
            starve_cnt_next = '0;
        else if (starve_cnt_reg != CNT_W'(STARVE_LIMIT))
            starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    // Address is zeroed on idle cycles so the regfile bypass never matches stale data.
    always_comb begin
        granted       = a_ready | b_ready;
        grant_wa      = b_ready ? b_wa : a_wa;
        grant_wdata   = b_ready ? b_wdata : a_wdata;
        rf_wen_next   = granted & (grant_wa != ADDR_SIZE'(R0));
        rf_wa_next    = rf_wen_next ? grant_wa : '0;
        rf_wdata_next = rf_wen_next ? grant_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
            rf_wen         <= 1'b0;
            rf_wa          <= '0;
            rf_wdata       <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            rf_wen         <= rf_wen_next;
            rf_wa          <= rf_wa_next;
            rf_wdata       <= rf_wdata_next;
        end
    end
endmodule

// File: rtl/ee457_regfile_wb_sched.sv
// Register-file write-port scheduler with a per-register busy scoreboard that
// stalls issue on RAW/WAW hazards against pending long-unit writes.
module ee457_regfile_wb_sched
    import ee457_cpu_pkg::*;
#(
    parameter int ADDR_SIZE    = ADDR_SIZE_DEF,
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_valid,
    input  logic [ADDR_SIZE-1:0] iss_ra,
    input  logic [ADDR_SIZE-1:0] iss_rb,
    input  logic [ADDR_SIZE-1:0] iss_wa,
    input  logic                 iss_wen,
    input  logic                 iss_long,
    output logic                 iss_stall,
    ee457_regfile_wb_sched_if.slave a,
    ee457_regfile_wb_sched_if.slave b,
    output logic                 rf_wen,
    output logic [ADDR_SIZE-1:0] rf_wa,
    output logic [DATA_SIZE-1:0] rf_wdata,
    output logic                 sb_busy_any
);
    localparam int NREG = 1 << ADDR_SIZE;

    logic [NREG-1:0] busy_reg;
    logic            iss_set;
    logic            b_clear;

    assign iss_stall = iss_valid & (busy_reg[iss_ra] | busy_reg[iss_rb] |
                                    (iss_wen & busy_reg[iss_wa]));
    assign iss_set   = iss_valid & ~iss_stall & iss_wen & iss_long;
    assign b_clear   = b.valid & b.ready;
    assign sb_busy_any = |busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == R0) begin : g_r0
                assign busy_reg[gi] = 1'b0;
            end else begin : g_rn
                // A set needs the bit clear (WAW stall) and a clear needs it set, so they never collide.
                always_ff @(posedge clk) begin
                    if (rst)
                        busy_reg[gi] <= 1'b0;
                    else if (iss_set && iss_wa == ADDR_SIZE'(gi))
                        busy_reg[gi] <= 1'b1;
                    else if (b_clear && b.wa == ADDR_SIZE'(gi))
                        busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    ee457_wb_arbiter #(
        .ADDR_SIZE   (ADDR_SIZE),
        .DATA_SIZE   (DATA_SIZE),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a.valid),
        .a_wa    (a.wa),
        .a_wdata (a.wdata),
        .a_ready (a.ready),
        .b_valid (b.valid),
        .b_wa    (b.wa),
        .b_wdata (b.wdata),
        .b_ready (b.ready),
        .rf_wen  (rf_wen),
        .rf_wa   (rf_wa),
        .rf_wdata(rf_wdata)
    );
endmodule

// File: tb/tb_ee457_regfile_wb_sched.sv
// Directed bench for the writeback scheduler: a vector table plus hand-written
// sequences for reset, arbitration starvation and mid-operation reset.
module tb_ee457_regfile_wb_sched;
    import ee457_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_wen, iss_long, iss_stall;
    logic [4:0]  iss_ra, iss_rb, iss_wa;
    logic        rf_wen, sb_busy_any;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    ee457_regfile_wb_sched_if #(.ADDR_SIZE(5), .DATA_SIZE(32)) a_if ();
    ee457_regfile_wb_sched_if #(.ADDR_SIZE(5), .DATA_SIZE(32)) b_if ();

    ee457_regfile_wb_sched #(.ADDR_SIZE(5), .DATA_SIZE(32), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_ra     (iss_ra),
        .iss_rb     (iss_rb),
        .iss_wa     (iss_wa),
        .iss_wen    (iss_wen),
        .iss_long   (iss_long),
        .iss_stall  (iss_stall),
        .a          (a_if),
        .b          (b_if),
        .rf_wen     (rf_wen),
        .rf_wa      (rf_wa),
        .rf_wdata   (rf_wdata),
        .sb_busy_any(sb_busy_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  ra, rb, wa;
        logic        wen, lng;
        wb_req_t     a, b;
        logic        e_stall, e_ar, e_br;
        logic        e_rf_wen;
        logic [4:0]  e_rf_wa;
        logic [31:0] e_rf_wdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs[13];

    function automatic wb_req_t req(input logic v, input logic [4:0] wa, input logic [31:0] d);
        wb_req_t r;
        r.valid = v; r.wa = wa; r.wdata = d;
        return r;
    endfunction

    function automatic vec_t mkv(input logic iv, input logic [4:0] ra, rb, wa,
                                 input logic wen, lng, input wb_req_t ar, br,
                                 input logic es, ea, eb, ew, input logic [4:0] ewa,
                                 input logic [31:0] ed, input logic ebusy);
        vec_t v;
        v.iv = iv; v.ra = ra; v.rb = rb; v.wa = wa; v.wen = wen; v.lng = lng;
        v.a = ar; v.b = br;
        v.e_stall = es; v.e_ar = ea; v.e_br = eb;
        v.e_rf_wen = ew; v.e_rf_wa = ewa; v.e_rf_wdata = ed; v.e_busy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] ra, rb, wa,
                         input logic wen, lng, input wb_req_t ar, br);
        iss_valid = iv; iss_ra = ra; iss_rb = rb; iss_wa = wa;
        iss_wen = wen; iss_long = lng;
        a_if.valid = ar.valid; a_if.wa = ar.wa; a_if.wdata = ar.wdata;
        b_if.valid = br.valid; b_if.wa = br.wa; b_if.wdata = br.wdata;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, req(0, 0, 0), req(0, 0, 0));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wb_req_t nq;
        nq = req(0, 0, 0);

        vecs[0]  = mkv(0, 0, 0, 0, 0, 0, nq, nq,                    0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 1, 2, 5, 1, 1, nq, nq,                    0, 0, 0, 0, 0, 0, 1);
        vecs[2]  = mkv(1, 5, 0, 0, 0, 0, nq, nq,                    1, 0, 0, 0, 0, 0, 1);
        vecs[3]  = mkv(1, 5, 0, 0, 0, 0, nq, req(1, 5, 32'hDEADBEEF), 1, 0, 1, 1, 5, 32'hDEADBEEF, 0);
        vecs[4]  = mkv(1, 5, 0, 0, 0, 0, nq, nq,                    0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mkv(1, 0, 0, 0, 1, 1, nq, nq,                    0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mkv(1, 0, 0, 7, 1, 1, nq, nq,                    0, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mkv(1, 1, 2, 7, 1, 0, nq, nq,                    1, 0, 0, 0, 0, 0, 1);
        vecs[8]  = mkv(1, 1, 2, 7, 0, 0, nq, nq,                    0, 0, 0, 0, 0, 0, 1);
        vecs[9]  = mkv(0, 0, 0, 0, 0, 0, req(1, 0, 32'h1234), nq,   0, 1, 0, 0, 0, 0, 1);
        vecs[10] = mkv(0, 0, 0, 0, 0, 0, req(1, 3, 32'h33), nq,     0, 1, 0, 1, 3, 32'h33, 1);
        vecs[11] = mkv(0, 0, 0, 0, 0, 0, nq, nq,                    0, 0, 0, 0, 0, 0, 1);
        vecs[12] = mkv(1, 7, 0, 0, 0, 0, nq, req(1, 7, 32'h77),     1, 0, 1, 1, 7, 32'h77, 0);

        // Reset held two cycles with both sources requesting.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, req(1, 9, 32'h99), req(1, 10, 32'hAA));
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_rf_wen", rf_wen, 0);
            check("rst_rf_wa", rf_wa, 0);
            check("rst_busy_any", sb_busy_any, 0);
        end
        rst = 1'b0;
        #3;
        check("post_rst_a_ready", a_if.ready, 1);
        check("post_rst_b_ready", b_if.ready, 0);
        idle();
        #1;
        check("idle_a_ready", a_if.ready, 0);
        check("idle_b_ready", b_if.ready, 0);
        check("idle_stall", iss_stall, 0);
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].iv, vecs[i].ra, vecs[i].rb, vecs[i].wa,
                  vecs[i].wen, vecs[i].lng, vecs[i].a, vecs[i].b);
            #3;
            check($sformatf("v%0d_stall", i), iss_stall, vecs[i].e_stall);
            check($sformatf("v%0d_a_ready", i), a_if.ready, vecs[i].e_ar);
            check($sformatf("v%0d_b_ready", i), b_if.ready, vecs[i].e_br);
            tick();
            check($sformatf("v%0d_rf_wen", i), rf_wen, vecs[i].e_rf_wen);
            check($sformatf("v%0d_rf_wa", i), rf_wa, vecs[i].e_rf_wa);
            check($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_rf_wdata);
            check($sformatf("v%0d_busy_any", i), sb_busy_any, vecs[i].e_busy);
            $display("vector %0d: stall=%0b a_ready=%0b b_ready=%0b rf_wen=%0b rf_wa=%0d rf_wdata=%0h busy_any=%0b",
                     i, iss_stall, a_if.ready, b_if.ready, rf_wen, rf_wa, rf_wdata, sb_busy_any);
        end

        // Starvation: B pending on r6 while A requests every cycle.
        idle();
        drive(1, 0, 0, 6, 1, 1, nq, nq);
        tick();
        for (int c = 0; c < 6; c++) begin
            logic exp_b;
            exp_b = (c == 4);
            drive(0, 0, 0, 0, 0, 0, req(1, 2, 32'hA0 + c), req(1, 6, 32'h6666));
            #3;
            check($sformatf("arb%0d_a_ready", c), a_if.ready, !exp_b);
            check($sformatf("arb%0d_b_ready", c), b_if.ready, exp_b);
            tick();
            check($sformatf("arb%0d_rf_wa", c), rf_wa, exp_b ? 6 : 2);
            check($sformatf("arb%0d_rf_wdata", c), rf_wdata, exp_b ? 32'h6666 : 32'hA0 + c);
            check($sformatf("arb%0d_busy_any", c), sb_busy_any, c < 4);
            $display("arb cycle %0d: rf_wen=%0b rf_wa=%0d rf_wdata=%0h", c, rf_wen, rf_wa, rf_wdata);
        end

        // Mid-operation reset: set busy on r9, then reset with a pending A write.
        idle();
        drive(1, 0, 0, 9, 1, 1, nq, nq);
        tick();
        check("mid_busy_set", sb_busy_any, 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, req(1, 3, 32'h5555), nq);
        tick();
        rst = 1'b0;
        idle();
        check("mid_rst_rf_wen", rf_wen, 0);
        check("mid_rst_rf_wa", rf_wa, 0);
        check("mid_rst_busy_any", sb_busy_any, 0);
        drive(1, 9, 0, 0, 0, 0, nq, nq);
        #1;
        check("mid_rst_no_stall", iss_stall, 0);
        $display("mid reset: rf_wen=%0b busy_any=%0b stall=%0b", rf_wen, sb_busy_any, iss_stall);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ee457_regfile_wb_sched.md
# ee457_regfile_wb_sched

Write-port scheduler and scoreboard for the 2-read/1-write register file in the pipelined CPU. Two writeback sources share the single write port through valid/ready arbitration:
- Port A: the main pipeline WB stage.
- Port B: the multi-cycle long-latency unit (mul/div/load-miss).

A per-register busy scoreboard stalls issue of any instruction that reads or overwrites a register with a pending long-unit write. Register-file write signals are driven from one registered stage.

## Interface
Parameters:
- ADDR_SIZE, 5, register address width
- DATA_SIZE, 32, register data width
- STARVE_LIMIT, 4, consecutive cycles port B may lose arbitration before it is forced to win

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- iss_valid  in  1  decode stage presents an instruction
- iss_ra, iss_rb  in  ADDR_SIZE  source registers
- iss_wa  in  ADDR_SIZE  destination register
- iss_wen  in  1  instruction writes iss_wa
- iss_long  in  1  destination is produced by the long unit
- iss_stall  out  1  hold decode; instruction not accepted
- a_valid, a_wa, a_wdata  in  1/ADDR_SIZE/DATA_SIZE  pipeline writeback request
- a_ready  out  1  port A accepted this cycle
- b_valid, b_wa, b_wdata  in  1/ADDR_SIZE/DATA_SIZE  long-unit writeback request
- b_ready  out  1  port B accepted this cycle
- rf_wen, rf_wa, rf_wdata  out  1/ADDR_SIZE/DATA_SIZE  to register-file write port
- sb_busy_any  out  1  OR of all busy bits

## Operation
- Scoreboard: busy[0..2^ADDR_SIZE-1], reset all 0; busy[0] is hard-wired 0.
- iss_stall = iss_valid & (busy[iss_ra] | busy[iss_rb] | (iss_wen & busy[iss_wa])). WAW is stalled, not renamed.
- Set: iss_valid & !iss_stall & iss_wen & iss_long & iss_wa!=0 sets busy[iss_wa] at the clock edge.
- Clear: a port-B handshake (b_valid & b_ready) clears busy[b_wa] at the clock edge.
- Set and clear never collide on one register: set requires !busy because of WAW stall, and clear requires busy.
- Arbitration: one grant per cycle.
  - Default is A priority: a_ready = a_valid & !force_b; b_ready = b_valid & (!a_valid | force_b).
  - starve_cnt increments each cycle b_valid & !b_ready, saturating at STARVE_LIMIT.
  - starve_cnt resets to 0 on a port-B handshake or when !b_valid.
  - force_b = (starve_cnt == STARVE_LIMIT).
- Ready is combinational from valid; sources must hold valid/wa/wdata stable until ready.
- A handshake with wa==0 is accepted, but rf_wen stays 0 (write discarded).
- Output stage, registered:
  - rf_wen <= granted & wa!=0.
  - rf_wa/rf_wdata <= granted wa/wdata when rf_wen is next 1, else 0.
  - rf_wa is forced to 0 whenever rf_wen=0. This prevents the register file's address-match read bypass from returning stale rf_wdata.

## Timing
- Reset values: rf_wen=0, rf_wa=0, rf_wdata=0, all busy=0, starve_cnt=0, sb_busy_any=0.
- Ready/stall outputs are combinational; with no valids they are 0.
- Reset mid-operation clears all busy bits and starve_cnt, and drops any registered write. The long unit is reset by the same rst.
- Latency: handshake in cycle n → rf_wen=1 in cycle n+1 → the register file commits at the end of cycle n+1.
- Read-after-writeback: busy clears at the end of cycle n, so a stalled reader issues in cycle n+1. Its same-cycle regfile read is covered by the regfile's wa==ra bypass of rf_wdata.
- Both valid with starve_cnt<STARVE_LIMIT: A wins.
- With A valid continuously, B is granted no later than STARVE_LIMIT+1 cycles after b_valid rises.
- sb_busy_any reflects registered busy state (the cycle after a set/clear edge).

## Structure
- Shared package ee457_cpu_pkg: ADDR_SIZE/DATA_SIZE defaults, the r0 constant, and the wb request struct (valid, wa, wdata) used by ports A/B.
- One sub-module, ee457_wb_arbiter: two-input priority arbiter with starvation counter and registered output stage.
- The scoreboard and stall logic stay in the top module.

## Test plan
- Reset: assert rst 2 cycles with a_valid=b_valid=1 → rf_wen=0, rf_wa=0, a_ready/b_ready reflect valids only after reset; all busy=0.
- Scoreboard RAW:
  - Issue iss_long to r5 → busy[5]=1.
  - Next issue with iss_ra=5 → iss_stall=1 until b handshake with b_wa=5, b_wdata=32'hDEADBEEF.
  - Stall drops the following cycle, when rf_wen=1, rf_wa=5, rf_wdata=32'hDEADBEEF.
- WAW and r0:
  - Issue long to r0 → no busy bit set.
  - With busy[7], an issue with iss_wen=1, iss_wa=7 stalls.
  - An issue with iss_wen=0, iss_wa=7 does not stall.
- Arbitration: a_valid=b_valid=1 held → A granted 4 cycles, B granted on the 5th (STARVE_LIMIT=4), then A resumes and starve_cnt=0.
- Zero-address write: a handshake with a_wa=0, a_wdata=32'h1234 → rf_wen=0, rf_wa=0 next cycle.
- Idle output: after one write, drop valids → rf_wa returns to 0 and rf_wen=0 the next cycle.
